mm_feat_buf: RTL and testbench
==============================

MM_FEAT_BUF -- requirements
Module: mm_feat_buf

Interface
REQ-001 SHALL have parameter AW, default 11, meaning address width.
REQ-002 SHALL have parameter DEPTH, default 2048, meaning number of 512-bit words; DEPTH <= 2^AW.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_addr_valid  in  1  engine read request.
REQ-007 SHALL have port rd_addr  in  AW  engine read word address.
REQ-008 SHALL have port rd_data  out  512  engine read data.
REQ-009 SHALL have port rd_data_valid  out  1  engine read data qualifier.
REQ-010 SHALL have port wr_valid  in  1  engine write strobe.
REQ-011 SHALL have port wr_addr  in  AW  engine write word address.
REQ-012 SHALL have port wr_data  in  512  engine write data.
REQ-013 SHALL have port engine_busy  in  1  engine running (high from start_valid until done).
REQ-014 SHALL have port host_req, host_we  in  1 each  host access request, 1 = write.
REQ-015 SHALL have port host_addr  in  AW; host_wdata  in  512.
REQ-016 SHALL have port host_gnt  out  1  host request accepted this cycle.
REQ-017 SHALL have port host_rdata  out  512; host_rvalid  out  1.
REQ-018 SHALL have port err_oob  out  1  sticky out-of-range access flag; clr_err  in  1  clears it.

Function
REQ-019 SHALL store DEPTH x 512-bit words in a simple dual-port array (one read, one write per cycle).
REQ-020 SHALL, for rd_addr_valid high in cycle t, drive rd_data_valid high in cycle t+RD_LAT with mem[rd_addr] sampled at cycle t; one result per request, back-to-back requests every cycle.
REQ-021 SHALL drive rd_data to zero whenever rd_data_valid is low.
REQ-022 SHALL write wr_data to mem[wr_addr] at the rising edge ending any cycle with wr_valid high.
REQ-023 SHALL serve an engine read and an engine write in the same cycle to different addresses without stall.
REQ-024 SHALL assert host_gnt combinationally iff host_req & ~engine_busy & ~rd_addr_valid & ~wr_valid; the engine always has priority, with no engine stall.
REQ-025 SHALL perform a granted host write as an engine write; a granted host read returns host_rdata with host_rvalid exactly RD_LAT cycles after grant; host_rdata SHALL be zero when host_rvalid is low.
REQ-026 SHALL hold an ungranted host request unserved; the host keeps host_req asserted until host_gnt.
REQ-027 SHALL treat any access with address >= DEPTH as out of range: no write occurs, the read returns zero data with normal valid timing, and err_oob sets the next cycle.
REQ-028 SHALL clear err_oob one cycle after clr_err; if set and clear happen in the same cycle, set SHALL win.
REQ-029 SHALL, in a cycle where engine_busy falls, still complete all in-flight reads with unchanged latency.

Reset
REQ-030 SHALL on rstn low clear the read-valid pipelines, rd_data_valid, host_rvalid and err_oob to 0, and rd_data and host_rdata to zero; array contents are not reset.
REQ-031 SHALL discard reads in flight when reset asserts mid-operation; no valid appears after reset release for pre-reset requests.

Configuration
REQ-032 SHALL honour macro MM_FEAT_BUF_BYPASS_EN: when defined, a read and a write to the same address in the same cycle return the new wr_data.
REQ-033 SHALL, without MM_FEAT_BUF_BYPASS_EN, return the old contents for a same-cycle, same-address read and write; the written value becomes visible from cycle t+1 requests.

Verification
REQ-034 SHALL cover: host writes 0xA5.. to addr 5, engine_busy=0; engine reads addr 5 at t -> rd_data_valid and 0xA5.. at t+2.
REQ-035 SHALL cover: engine reads addr 0..7 on 8 consecutive cycles -> 8 consecutive valids, data in order, no gaps.
REQ-036 SHALL cover: same-cycle wr/rd to addr 9, old=1, new=2 -> read returns 2 with the macro, 1 without.
REQ-037 SHALL cover: host_req held while engine_busy=1 for 10 cycles -> host_gnt=0 throughout; after engine_busy falls with no engine traffic, host_gnt=1 that cycle.
REQ-038 SHALL cover: DEPTH=1024 and read of addr 1500 -> data 0, valid at t+2, err_oob=1 at t+1; clr_err -> err_oob=0 next cycle.
REQ-039 SHALL cover: reset pulsed one cycle after a read request -> no rd_data_valid after release, and previously written contents intact.

Source files
------------

// File: rtl/mm_feat_buf_if.sv
// Engine/host access bundle for the feature buffer.
// master: engine + host side driving requests; slave: the buffer itself.
interface mm_feat_buf_if #(
    parameter int unsigned AW = 11
);
    localparam int unsigned DW = 512;

    // Engine read port
    logic          rd_addr_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;

    // Engine write port
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          engine_busy;

    // Host access port
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    // Out-of-range error flag
    logic          err_oob;
    logic          clr_err;

    modport master (
        output rd_addr_valid, rd_addr, wr_valid, wr_addr, wr_data, engine_busy,
               host_req, host_we, host_addr, host_wdata, clr_err,
        input  rd_data, rd_data_valid, host_gnt, host_rdata, host_rvalid, err_oob
    );

    modport slave (
        input  rd_addr_valid, rd_addr, wr_valid, wr_addr, wr_data, engine_busy,
               host_req, host_we, host_addr, host_wdata, clr_err,
        output rd_data, rd_data_valid, host_gnt, host_rdata, host_rvalid, err_oob
    );
endinterface

// File: rtl/mm_feat_buf.sv
// Feature buffer: DEPTH x 512-bit simple dual-port store shared by the
// engine (always first) and a host port that is only granted on idle cycles.
// Optional macro MM_FEAT_BUF_BYPASS_EN: a same-cycle read and write to the
// same address returns the new write data instead of the old contents.
module mm_feat_buf #(
    parameter int unsigned AW     = 11,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    mm_feat_buf_if.slave  bus
);
    localparam int unsigned DW   = 512;
    localparam int unsigned AW1  = AW + 1;
    localparam int unsigned MAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAST = RD_LAT - 1;
    localparam logic [AW:0] DEPTH_L = AW1'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          host_gnt_w;
    logic          rd_any;
    logic          rd_host;
    logic [AW-1:0] rd_addr_sel;
    logic          rd_oob;
    logic [MAW-1:0] rd_idx;
    logic          wr_any;
    logic [AW-1:0] wr_addr_sel;
    logic [DW-1:0] wr_data_sel;
    logic          wr_oob;
    logic          wr_do;
    logic [MAW-1:0] wr_idx;
    logic          byp_hit;
    logic          oob_set;

    logic [RD_LAT-1:0] pe_v;
    logic [RD_LAT-1:0] ph_v;
    logic [DW-1:0]     pd [RD_LAT];
    logic              err_q;

    // Host is served only on cycles with no engine activity at all
    assign host_gnt_w = bus.host_req & ~bus.engine_busy & ~bus.rd_addr_valid & ~bus.wr_valid;
    assign bus.host_gnt = host_gnt_w;

    // Port arbitration: engine request if present, otherwise granted host access
    assign rd_host     = host_gnt_w & ~bus.host_we;
    assign rd_any      = bus.rd_addr_valid | rd_host;
    assign rd_addr_sel = bus.rd_addr_valid ? bus.rd_addr : bus.host_addr;
    assign wr_any      = bus.wr_valid | (host_gnt_w & bus.host_we);
    assign wr_addr_sel = bus.wr_valid ? bus.wr_addr : bus.host_addr;
    assign wr_data_sel = bus.wr_valid ? bus.wr_data : bus.host_wdata;

    assign rd_oob  = {1'b0, rd_addr_sel} >= DEPTH_L;
    assign wr_oob  = {1'b0, wr_addr_sel} >= DEPTH_L;
    assign wr_do   = wr_any & ~wr_oob;
    assign oob_set = (rd_any & rd_oob) | (wr_any & wr_oob);
    assign rd_idx  = rd_addr_sel[MAW-1:0];
    assign wr_idx  = wr_addr_sel[MAW-1:0];

`ifdef MM_FEAT_BUF_BYPASS_EN
    assign byp_hit = rd_any & wr_do & (rd_addr_sel == wr_addr_sel);
`else
    assign byp_hit = 1'b0;
`endif

    // Array write port; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_idx] <= wr_data_sel;
        end
    end

    // Read data pipeline (not reset; qualified by the valid pipeline)
    always_ff @(posedge clk) begin
        if (rd_any) begin
            pd[0] <= rd_oob ? '0 : (byp_hit ? wr_data_sel : mem[rd_idx]);
        end
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pd[i] <= pd[i-1];
        end
    end

    // Valid pipeline tagging each read as engine or host; reset drops in-flight reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_v <= '0;
            ph_v <= '0;
        end else begin
            pe_v[0] <= bus.rd_addr_valid;
            ph_v[0] <= rd_host;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pe_v[i] <= pe_v[i-1];
                ph_v[i] <= ph_v[i-1];
            end
        end
    end

    // Sticky out-of-range flag; a new violation wins over a clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (oob_set) begin
            err_q <= 1'b1;
        end else if (bus.clr_err) begin
            err_q <= 1'b0;
        end
    end

    assign bus.rd_data_valid = pe_v[LAST];
    assign bus.rd_data       = pe_v[LAST] ? pd[LAST] : '0;
    assign bus.host_rvalid   = ph_v[LAST];
    assign bus.host_rdata    = ph_v[LAST] ? pd[LAST] : '0;
    assign bus.err_oob       = err_q;

endmodule

// File: tb/tb_mm_feat_buf.sv
// Scoreboard bench for mm_feat_buf: driver pushes expected reads, monitor checks.
module tb_mm_feat_buf;
    localparam int unsigned AW     = 11;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DW     = 512;
`ifdef MM_FEAT_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mm_feat_buf_if #(.AW(AW)) bus ();

    mm_feat_buf #(.AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t eng_q[$];
    exp_t host_q[$];
    logic [DW-1:0] mdl [int];
    bit   err_cur = 1'b0;
    bit   err_exp = 1'b0;
    bit   gnt_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    // One bus cycle: drive inputs, predict from the reference model, advance.
    task automatic step(input bit busy, input bit rv, input logic [AW-1:0] ra,
                        input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit hreq, input bit hwe, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hwd, input bit clr, output bit gnt);
        bit rd_e, wr_e, rd_h;
        logic [AW-1:0] radr, wadr;
        logic [DW-1:0] wdat, rexp;
        exp_t e;
        bus.engine_busy   = busy;
        bus.rd_addr_valid = rv;
        bus.rd_addr       = ra;
        bus.wr_valid      = wv;
        bus.wr_addr       = wa;
        bus.wr_data       = wd;
        bus.host_req      = hreq;
        bus.host_we       = hwe;
        bus.host_addr     = ha;
        bus.host_wdata    = hwd;
        bus.clr_err       = clr;
        gnt  = hreq && !busy && !rv && !wv;
        rd_h = gnt && !hwe;
        rd_e = rv || rd_h;
        radr = rv ? ra : ha;
        wr_e = wv || (gnt && hwe);
        wadr = wv ? wa : ha;
        wdat = wv ? wd : hwd;
        if (rd_e) begin
            if (radr >= AW'(DEPTH)) rexp = '0;
            else if (BYP && wr_e && wadr == radr) rexp = wdat;
            else if (mdl.exists(int'(radr))) rexp = mdl[int'(radr)];
            else rexp = '0;
            e.due  = cyc + int'(RD_LAT);
            e.data = rexp;
            if (rd_h) host_q.push_back(e);
            else      eng_q.push_back(e);
        end
        gnt_exp = gnt;
        err_exp = err_cur;
        @(posedge clk);
        #1;
        if (wr_e && wadr < AW'(DEPTH)) mdl[int'(wadr)] = wdat;
        err_cur = (rd_e && radr >= AW'(DEPTH)) || (wr_e && wadr >= AW'(DEPTH)) || (err_cur && !clr);
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0, 0, 0, '0, '0, 0, g);
    endtask

    task automatic eng_rd(input logic [AW-1:0] a);
        bit g;
        step(1, 1, a, 0, '0, '0, 0, 0, '0, '0, 0, g);
    endtask

    task automatic host_acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit g;
        g = 1'b0;
        for (int i = 0; i < 50 && !g; i++) step(0, 0, '0, 0, '0, '0, 1, we, a, d, 0, g);
    endtask

    task automatic pulse_reset();
        bus.engine_busy = 0; bus.rd_addr_valid = 0; bus.wr_valid = 0;
        bus.host_req = 0; bus.host_we = 0; bus.clr_err = 0;
        rstn = 1'b0;
        eng_q.delete();
        host_q.delete();
        err_cur = 1'b0;
        err_exp = 1'b0;
        gnt_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output against the scoreboard each cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            n_vec++;
            if (bus.rd_data_valid !== 1'b0 || bus.host_rvalid !== 1'b0 || bus.err_oob !== 1'b0 ||
                bus.rd_data !== '0 || bus.host_rdata !== '0) begin
                n_err++;
                $display("FAIL reset_state: rdv=%b hrv=%b err=%b, required all 0", bus.rd_data_valid,
                         bus.host_rvalid, bus.err_oob);
            end
        end else begin
            while (eng_q.size() > 0 && eng_q[0].due < cyc) begin
                n_vec++; n_err++;
                $display("FAIL eng_missing: no rd_data_valid at cycle %0d, required one", eng_q[0].due);
                void'(eng_q.pop_front());
            end
            n_vec++;
            if (bus.rd_data_valid) begin
                if (eng_q.size() == 0) begin
                    n_err++;
                    $display("FAIL eng_unexpected: rd_data_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = eng_q.pop_front();
                    if (e.due != cyc || e.data !== bus.rd_data) begin
                        n_err++;
                        $display("FAIL eng_data: cycle %0d got %h, required %h at cycle %0d",
                                 cyc, bus.rd_data, e.data, e.due);
                    end
                end
            end else if (bus.rd_data !== '0) begin
                n_err++;
                $display("FAIL eng_zero: rd_data=%h while invalid, required 0", bus.rd_data);
            end

            while (host_q.size() > 0 && host_q[0].due < cyc) begin
                n_vec++; n_err++;
                $display("FAIL host_missing: no host_rvalid at cycle %0d, required one", host_q[0].due);
                void'(host_q.pop_front());
            end
            n_vec++;
            if (bus.host_rvalid) begin
                if (host_q.size() == 0) begin
                    n_err++;
                    $display("FAIL host_unexpected: host_rvalid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = host_q.pop_front();
                    if (e.due != cyc || e.data !== bus.host_rdata) begin
                        n_err++;
                        $display("FAIL host_data: cycle %0d got %h, required %h at cycle %0d",
                                 cyc, bus.host_rdata, e.data, e.due);
                    end
                end
            end else if (bus.host_rdata !== '0) begin
                n_err++;
                $display("FAIL host_zero: host_rdata=%h while invalid, required 0", bus.host_rdata);
            end

            n_vec++;
            if (bus.host_gnt !== gnt_exp) begin
                n_err++;
                $display("FAIL host_gnt: cycle %0d got %b, required %b", cyc, bus.host_gnt, gnt_exp);
            end
            n_vec++;
            if (bus.err_oob !== err_exp) begin
                n_err++;
                $display("FAIL err_oob: cycle %0d got %b, required %b", cyc, bus.err_oob, err_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        bit hpend, hwe;
        logic [AW-1:0] ha, ra, wa;
        logic [DW-1:0] hd;
        bus.engine_busy = 0; bus.rd_addr_valid = 0; bus.rd_addr = '0;
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.clr_err = 0;
        pulse_reset();

        // Preload a working set through the host port
        for (int a = 0; a < 64; a++) host_acc(1, AW'(a), rnd_word());

        // Host write 0xA5.. to addr 5, engine reads it back
        host_acc(1, AW'(5), {64{8'hA5}});
        eng_rd(AW'(5));
        idle(3);
        host_acc(0, AW'(5), '0);
        idle(3);

        // Eight back-to-back engine reads
        for (int a = 0; a < 8; a++) eng_rd(AW'(a));
        idle(3);

        // Same-cycle read/write at addr 9, and at different addresses
        host_acc(1, AW'(9), DW'(1));
        step(1, 1, AW'(9), 1, AW'(9), DW'(2), 0, 0, '0, '0, 0, g);
        eng_rd(AW'(9));
        step(1, 1, AW'(10), 1, AW'(11), rnd_word(), 0, 0, '0, '0, 0, g);
        eng_rd(AW'(11));
        idle(3);

        // Host held off for 10 busy cycles, granted when the engine goes quiet
        for (int i = 0; i < 10; i++) step(1, 0, '0, 0, '0, '0, 1, 0, AW'(3), '0, 0, g);
        step(0, 0, '0, 0, '0, '0, 1, 0, AW'(3), '0, 0, g);
        idle(3);

        // Out-of-range read, clear, and set-wins-over-clear
        eng_rd(AW'(1500));
        idle(2);
        step(0, 0, '0, 0, '0, '0, 0, 0, '0, '0, 1, g);
        idle(2);
        step(1, 0, '0, 1, AW'(2000), rnd_word(), 0, 0, '0, '0, 0, g);
        step(1, 1, AW'(1024), 0, '0, '0, 0, 0, '0, '0, 1, g);
        step(0, 0, '0, 0, '0, '0, 0, 0, '0, '0, 1, g);
        idle(3);

        // Reset one cycle after a read: read is dropped, contents survive
        eng_rd(AW'(20));
        pulse_reset();
        idle(5);
        eng_rd(AW'(20));
        eng_rd(AW'(5));
        idle(3);

        // Randomized traffic
        hpend = 1'b0; hwe = 1'b0; ha = '0; hd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hpend && ($urandom_range(0, 3) == 0)) begin
                hpend = 1'b1;
                hwe   = $urandom_range(0, 1) == 1;
                ha    = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1024, 2047))
                                                    : AW'($urandom_range(0, 63));
                hd    = rnd_word();
            end
            ra = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(1024, 2047)) : AW'($urandom_range(0, 63));
            wa = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(1024, 2047)) : AW'($urandom_range(0, 63));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra,
                 $urandom_range(0, 2) == 0, wa, rnd_word(),
                 hpend, hwe, ha, hd, $urandom_range(0, 15) == 0, g);
            if (g) hpend = 1'b0;
        end

        idle(int'(RD_LAT) + 3);
        n_vec++;
        if (eng_q.size() != 0 || host_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d engine and %0d host reads outstanding, required 0",
                     eng_q.size(), host_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
